// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg: shared operand-source encodings and FSM states for the
// hazard / forwarding controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] SRC_RF    = 2'b00;
  localparam logic [1:0] SRC_EXMEM = 2'b01;
  localparam logic [1:0] SRC_MEMWB = 2'b10;
  localparam logic [1:0] SRC_IMM   = 2'b11;

  // MDU_LAT is limited to 1..15, so four bits cover the countdown
  localparam int MDU_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MDU_WAIT = 2'b10
  } haz_state_t;

endpackage

`default_nettype wire

// File: rtl/fwd_sel.sv
// ============================================================================
// fwd_sel: operand-source select for one register read in ID.
// Nearest producing stage wins; register 0 never matches.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic              idex_regwr,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              exmem_regwr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_regwr,
  input  logic [REG_AW-1:0] memwb_rd,
  output logic [1:0]        sel,
  output logic              byp
);

  logic hit_idex;
  logic hit_exmem;
  logic hit_memwb;

  assign hit_idex  = use_src && idex_regwr  && (idex_rd  != '0) && (idex_rd  == src);
  assign hit_exmem = use_src && exmem_regwr && (exmem_rd != '0) && (exmem_rd == src);
  assign hit_memwb = use_src && memwb_regwr && (memwb_rd != '0) && (memwb_rd == src);

  // Selects are named by where the producer will sit once this operand is in EX
  always_comb begin
    sel = SRC_RF;
    if (hit_idex) begin
      sel = SRC_EXMEM;
    end else if (hit_exmem) begin
      sel = SRC_MEMWB;
    end
  end

  assign byp = hit_memwb && !hit_idex && !hit_exmem;

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
// ============================================================================
// hazard_fwd_ctrl: registered EX forwarding selects, load-use / MDU stall
// control and ID write-back bypass flags. Macro HAZ_PERF_EN adds counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4
`ifdef HAZ_PERF_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_alusrc,
  input  logic              id_mdu_op,
  input  logic              id_mdu_rd,
  input  logic              idex_regwr,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_memrd,
  input  logic              exmem_regwr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_regwr,
  input  logic [REG_AW-1:0] memwb_rd,
  output logic [1:0]        ex_src_a,
  output logic [1:0]        ex_src_b,
  output logic [1:0]        ex_src_st,
  output logic              id_byp_a,
  output logic              id_byp_b,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_flush,
  output logic              mdu_busy
`ifdef HAZ_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_lu_cnt,
  output logic [CNT_W-1:0]  perf_md_cnt
`endif
);

  logic [1:0]           sel_a;
  logic [1:0]           sel_b;
  logic [1:0]           sel_st;
  logic                 byp_b_alu;
  logic                 byp_b_st;
  logic                 lu;
  logic                 md;
  logic                 stall;
  haz_state_t           state;
  logic [MDU_CNT_W-1:0] mdu_cnt;
  logic [MDU_CNT_W-1:0] mdu_cnt_nxt;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src(id_rs), .use_src(id_use_rs),
    .idex_regwr(idex_regwr), .idex_rd(idex_rd),
    .exmem_regwr(exmem_regwr), .exmem_rd(exmem_rd),
    .memwb_regwr(memwb_regwr), .memwb_rd(memwb_rd),
    .sel(sel_a), .byp(id_byp_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src(id_rt), .use_src(id_use_rt && !id_alusrc),
    .idex_regwr(idex_regwr), .idex_rd(idex_rd),
    .exmem_regwr(exmem_regwr), .exmem_rd(exmem_rd),
    .memwb_regwr(memwb_regwr), .memwb_rd(memwb_rd),
    .sel(sel_b), .byp(byp_b_alu)
  );

  // Store data reads Rt even when ALU operand B is the immediate
  fwd_sel #(.REG_AW(REG_AW)) u_fwd_st (
    .src(id_rt), .use_src(id_use_rt),
    .idex_regwr(idex_regwr), .idex_rd(idex_rd),
    .exmem_regwr(exmem_regwr), .exmem_rd(exmem_rd),
    .memwb_regwr(memwb_regwr), .memwb_rd(memwb_rd),
    .sel(sel_st), .byp(byp_b_st)
  );

  assign id_byp_b = byp_b_alu || byp_b_st;

  // In LU_STALL the ID/EX slot is a bubble, so the old load no longer counts
  assign lu = idex_memrd && ((sel_a == SRC_EXMEM) || (sel_st == SRC_EXMEM))
              && (state != LU_STALL);
  assign md = (id_mdu_op || id_mdu_rd) && mdu_busy;
  assign stall = lu || md;

  assign pc_stall   = stall;
  assign ifid_stall = stall;
  assign idex_flush = stall;

  always_comb begin
    mdu_cnt_nxt = mdu_cnt;
    if (id_mdu_op && !stall) begin
      mdu_cnt_nxt = MDU_CNT_W'(MDU_LAT);
    end else if (mdu_cnt != '0) begin
      mdu_cnt_nxt = mdu_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      mdu_cnt   <= '0;
      mdu_busy  <= 1'b0;
      ex_src_a  <= SRC_RF;
      ex_src_b  <= SRC_RF;
      ex_src_st <= SRC_RF;
    end else begin
      mdu_cnt  <= mdu_cnt_nxt;
      mdu_busy <= (mdu_cnt_nxt != '0);
      if (stall) begin
        ex_src_a  <= SRC_RF;
        ex_src_b  <= SRC_RF;
        ex_src_st <= SRC_RF;
      end else begin
        ex_src_a  <= sel_a;
        ex_src_b  <= id_alusrc ? SRC_IMM : sel_b;
        ex_src_st <= sel_st;
      end
      case (state)
        RUN: begin
          if (lu) begin
            state <= LU_STALL;
          end else if (md) begin
            state <= MDU_WAIT;
          end
        end
        LU_STALL: state <= RUN;
        MDU_WAIT: begin
          if (mdu_cnt_nxt == '0) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_cnt <= '0;
      perf_md_cnt <= '0;
    end else begin
      if (lu && !(&perf_lu_cnt)) begin
        perf_lu_cnt <= perf_lu_cnt + 1'b1;
      end
      if (md && !lu && !(&perf_md_cnt)) begin
        perf_md_cnt <= perf_md_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
// ============================================================================
// tb_hazard_fwd_ctrl: vector table, directed multi-cycle sequences and random
// stimulus against a behavioural pipeline-hazard model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_fwd_ctrl;

  localparam int MDU_LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, idex_rd, exmem_rd, memwb_rd;
  logic       id_use_rs, id_use_rt, id_alusrc, id_mdu_op, id_mdu_rd;
  logic       idex_regwr, idex_memrd, exmem_regwr, memwb_regwr;
  logic [1:0] ex_src_a, ex_src_b, ex_src_st;
  logic       id_byp_a, id_byp_b, pc_stall, ifid_stall, idex_flush, mdu_busy;
`ifdef HAZ_PERF_EN
  logic [15:0] perf_lu_cnt, perf_md_cnt;
`endif

  hazard_fwd_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_alusrc(id_alusrc), .id_mdu_op(id_mdu_op), .id_mdu_rd(id_mdu_rd),
    .idex_regwr(idex_regwr), .idex_rd(idex_rd), .idex_memrd(idex_memrd),
    .exmem_regwr(exmem_regwr), .exmem_rd(exmem_rd),
    .memwb_regwr(memwb_regwr), .memwb_rd(memwb_rd),
    .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_src_st(ex_src_st),
    .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_flush(idex_flush),
    .mdu_busy(mdu_busy)
`ifdef HAZ_PERF_EN
    ,
    .perf_lu_cnt(perf_lu_cnt), .perf_md_cnt(perf_md_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: cycles left on the MDU, whether the last cycle was a
  // load-use stall (masks lu), whether we are waiting on the MDU, counters.
  int         m_cnt;
  bit         m_in_lu;
  bit         m_in_md;
  logic [1:0] m_a, m_b, m_st;
  int         m_plu, m_pmd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic wr, input logic [4:0] rd,
                             input logic [4:0] x, input logic u);
    return u && wr && (rd != 0) && (rd == x);
  endfunction

  function automatic logic [1:0] nsel(input logic [4:0] x, input logic u);
    if (hit(idex_regwr, idex_rd, x, u))   return 2'b01;
    if (hit(exmem_regwr, exmem_rd, x, u)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit bypf(input logic [4:0] x, input logic u);
    return hit(memwb_regwr, memwb_rd, x, u) && nsel(x, u) == 2'b00;
  endfunction

  // One clock: check combinational outputs mid-cycle, advance, check registers.
  task automatic tick();
    bit         e_lu, e_md, e_stall;
    logic [1:0] na, nb, nst;
    #2;
    e_lu = idex_memrd && !m_in_lu &&
           (hit(idex_regwr, idex_rd, id_rs, id_use_rs) ||
            hit(idex_regwr, idex_rd, id_rt, id_use_rt));
    e_md = (id_mdu_op || id_mdu_rd) && (m_cnt > 0);
    e_stall = e_lu || e_md;
    chk("pc_stall",   pc_stall,   e_stall);
    chk("ifid_stall", ifid_stall, e_stall);
    chk("idex_flush", idex_flush, e_stall);
    chk("id_byp_a",   id_byp_a,   bypf(id_rs, id_use_rs));
    chk("id_byp_b",   id_byp_b,   bypf(id_rt, id_use_rt));
    na  = nsel(id_rs, id_use_rs);
    nb  = id_alusrc ? 2'b11 : nsel(id_rt, id_use_rt);
    nst = nsel(id_rt, id_use_rt);
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = 0; m_in_lu = 0; m_in_md = 0;
      m_a = 0; m_b = 0; m_st = 0; m_plu = 0; m_pmd = 0;
    end else begin
      if (e_stall) begin m_a = 0; m_b = 0; m_st = 0; end
      else begin m_a = na; m_b = nb; m_st = nst; end
      if (id_mdu_op && !e_stall) m_cnt = MDU_LAT;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
      if (m_in_lu) m_in_lu = 0;
      else if (m_in_md) m_in_md = (m_cnt != 0);
      else if (e_lu) m_in_lu = 1;
      else if (e_md) m_in_md = 1;
      if (e_lu && m_plu < 65535) m_plu++;
      if (e_md && !e_lu && m_pmd < 65535) m_pmd++;
    end
    chk("ex_src_a",  ex_src_a,  m_a);
    chk("ex_src_b",  ex_src_b,  m_b);
    chk("ex_src_st", ex_src_st, m_st);
    chk("mdu_busy",  mdu_busy,  m_cnt != 0);
`ifdef HAZ_PERF_EN
    chk("perf_lu_cnt", perf_lu_cnt, m_plu);
    chk("perf_md_cnt", perf_md_cnt, m_pmd);
`endif
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_alusrc = 0;
    id_mdu_op = 0; id_mdu_rd = 0;
    idex_regwr = 0; idex_rd = 0; idex_memrd = 0;
    exmem_regwr = 0; exmem_rd = 0; memwb_regwr = 0; memwb_rd = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, alu;
    logic       iw; logic [4:0] ird; logic imr;
    logic       ew; logic [4:0] erd;
    logic       mw; logic [4:0] mrd;
    logic       stall, bya, byb;
    logic [1:0] ea, eb, est;
  } vec_t;

  vec_t tv[10];

  initial begin
    //            rs rt urs urt alu iw ird imr ew erd mw mrd stl bya byb ea     eb     est
    tv[0] = '{5'd3, 5'd0, 1, 0, 0, 1, 5'd3, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 2'b01, 2'b00, 2'b00};
    tv[1] = '{5'd3, 5'd4, 1, 1, 0, 1, 5'd4, 0, 1, 5'd3, 0, 5'd0, 0, 0, 0, 2'b10, 2'b01, 2'b01};
    tv[2] = '{5'd0, 5'd0, 1, 1, 0, 1, 5'd0, 0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 2'b00, 2'b00, 2'b00};
    tv[3] = '{5'd7, 5'd7, 1, 1, 0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd7, 0, 1, 1, 2'b00, 2'b00, 2'b00};
    tv[4] = '{5'd7, 5'd7, 1, 1, 1, 0, 5'd0, 0, 1, 5'd7, 1, 5'd7, 0, 0, 0, 2'b10, 2'b11, 2'b10};
    tv[5] = '{5'd6, 5'd6, 1, 1, 0, 1, 5'd6, 0, 1, 5'd6, 1, 5'd6, 0, 0, 0, 2'b01, 2'b01, 2'b01};
    tv[6] = '{5'd2, 5'd1, 0, 1, 0, 1, 5'd2, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 2'b00};
    tv[7] = '{5'd9, 5'd9, 0, 1, 1, 1, 5'd9, 1, 0, 5'd0, 0, 5'd0, 1, 0, 0, 2'b00, 2'b00, 2'b00};
    tv[8] = '{5'd0, 5'd0, 1, 1, 0, 1, 5'd0, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 2'b00};
    tv[9] = '{5'd3, 5'd0, 1, 0, 0, 0, 5'd3, 0, 1, 5'd3, 0, 5'd0, 0, 0, 0, 2'b10, 2'b00, 2'b00};

    clear_inputs();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset ex_src_a",  ex_src_a,  2'b00);
    chk("reset ex_src_b",  ex_src_b,  2'b00);
    chk("reset ex_src_st", ex_src_st, 2'b00);
    chk("reset mdu_busy",  mdu_busy,  1'b0);
    m_cnt = 0; m_in_lu = 0; m_in_md = 0; m_a = 0; m_b = 0; m_st = 0;
    m_plu = 0; m_pmd = 0;
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      reset_dut();
      id_rs = tv[i].rs; id_rt = tv[i].rt; id_use_rs = tv[i].urs; id_use_rt = tv[i].urt;
      id_alusrc = tv[i].alu; idex_regwr = tv[i].iw; idex_rd = tv[i].ird;
      idex_memrd = tv[i].imr; exmem_regwr = tv[i].ew; exmem_rd = tv[i].erd;
      memwb_regwr = tv[i].mw; memwb_rd = tv[i].mrd;
      #1;
      chk($sformatf("vec%0d stall", i), pc_stall, tv[i].stall);
      chk($sformatf("vec%0d byp_a", i), id_byp_a, tv[i].bya);
      chk($sformatf("vec%0d byp_b", i), id_byp_b, tv[i].byb);
      tick();
      chk($sformatf("vec%0d ex_src_a", i),  ex_src_a,  tv[i].ea);
      chk($sformatf("vec%0d ex_src_b", i),  ex_src_b,  tv[i].eb);
      chk($sformatf("vec%0d ex_src_st", i), ex_src_st, tv[i].est);
    end

    // Load-use with a realistic pipeline advance: bubble, then load in EX/MEM
    reset_dut();
    idex_regwr = 1; idex_rd = 5; idex_memrd = 1; id_rt = 5; id_use_rt = 1;
    #1 chk("lu stall", pc_stall, 1'b1);
    tick();
    chk("lu bubble ex_src_b", ex_src_b, 2'b00);
    idex_regwr = 0; idex_rd = 0; idex_memrd = 0; exmem_regwr = 1; exmem_rd = 5;
    #1 chk("lu release", pc_stall, 1'b0);
    tick();
    chk("lu fwd ex_src_b", ex_src_b, 2'b10);

    // Load-use with inputs held: second cycle is masked, stall lasts one cycle
    reset_dut();
    idex_regwr = 1; idex_rd = 5; idex_memrd = 1; id_rs = 5; id_use_rs = 1;
    #1 chk("lu hold stall", pc_stall, 1'b1);
    tick();
    #1 chk("lu hold masked", pc_stall, 1'b0);
    tick();
    chk("lu hold ex_src_a", ex_src_a, 2'b01);

    // mult then mfhi: four stall cycles, then mfhi proceeds
    reset_dut();
    id_mdu_op = 1;
    #1 chk("mult issue stall", pc_stall, 1'b0);
    tick();
    chk("mult busy", mdu_busy, 1'b1);
    id_mdu_op = 0; id_mdu_rd = 1;
    for (int k = 0; k < MDU_LAT; k++) begin
      #1 chk($sformatf("mfhi stall %0d", k), pc_stall, 1'b1);
      tick();
    end
    chk("mdu busy fell", mdu_busy, 1'b0);
`ifdef HAZ_PERF_EN
    chk("perf_md_cnt", perf_md_cnt, 16'd4);
`endif
    #1 chk("mfhi proceeds", pc_stall, 1'b0);
    tick();

    // Reset during the second MDU stall cycle
    reset_dut();
    id_mdu_op = 1;
    tick();
    id_mdu_op = 0; id_mdu_rd = 1;
    tick();
    rst = 1;
    #1 chk("rst mid stall still stalling", pc_stall, 1'b1);
    tick();
    rst = 0;
    #1;
    chk("post rst busy", mdu_busy, 1'b0);
    chk("post rst stall", pc_stall, 1'b0);
    chk("post rst ex_src_a", ex_src_a, 2'b00);
    chk("post rst ex_src_b", ex_src_b, 2'b00);
    tick();

    // Random traffic on a small register window to provoke hazards
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom); id_alusrc = 1'($urandom);
      id_mdu_op = ($urandom_range(0, 7) == 0);
      id_mdu_rd = ($urandom_range(0, 3) == 0);
      idex_regwr = 1'($urandom); idex_rd = 5'($urandom_range(0, 3));
      idex_memrd = ($urandom_range(0, 2) == 0);
      exmem_regwr = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
      memwb_regwr = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
      rst = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
